present_encrypt_core: RTL and testbench
=======================================

Name: present_encrypt_core

Overview:
- Iterative 64-bit block encryption engine for the PRESENT-80 cipher; the encrypt-direction counterpart of the team's inverse-S-box decrypt path.
- Computes one substitution-permutation round per clock over 31 rounds, then applies the final key whitening.
- Accepts plaintext and key over a valid/ready handshake and returns ciphertext over a valid/ready handshake.
- Sits between the message framer (upstream) and the transport packer (downstream).

Parameters:
- BLOCK_W, 64, block width in bits; must be a multiple of 4.
- KEY_W, 80, key width in bits.
- NUM_ROUNDS, 31, number of SP rounds. Test vectors are valid only for the defaults.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext and key are presented.
- in_ready  out  1  core can accept a block.
- in_data  in  BLOCK_W  plaintext.
- in_key  in  KEY_W  cipher key.
- out_valid  out  1  ciphertext is available.
- out_ready  in  1  downstream accepts the ciphertext.
- out_data  out  BLOCK_W  ciphertext.

Behaviour:
- Reset values: state=IDLE, out_valid=0, out_data=0, round counter=0, internal state/key registers=0, in_ready=0 while rst is high.
- Reset mid-operation aborts the block with no output. After rst deasserts, the core is in IDLE.
- S-box, encrypt direction, index 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit i moves to position (16*i) mod 63 for i=0..62; bit 63 stays at 63.
- Round key K_r = key_reg[79:16].
- Key update after each round r:
  - rotate key_reg left by 61;
  - pass [79:76] through the S-box;
  - XOR [19:15] with r (5-bit round counter).
- FSM: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load state_reg=in_data, key_reg=in_key, rc=1; go to RUN.
- RUN (in_ready=0):
  - Each edge: state_reg = pLayer(Sbox(state_reg ^ K_rc)); key_reg = update(key_reg, rc); rc++.
  - On the edge where rc==NUM_ROUNDS: also register out_data = round result ^ K of the updated key (K_32); set out_valid=1; go to DONE.
- Latency: out_valid rises exactly NUM_ROUNDS (31) cycles after the accept edge. Throughput is 1 block per 32 cycles.
- DONE:
  - out_valid=1; out_data holds stable until out_valid && out_ready.
  - in_ready = out_ready (back-to-back acceptance).
- DONE with out_ready=1 and in_valid=1 on the same edge: the output handshake completes and the new block loads. Next state is RUN; out_valid drops to 0.
- DONE with out_ready=1 and in_valid=0: go to IDLE; out_valid=0.
- Input changes during RUN or DONE are ignored, since inputs are sampled only on acceptance.
- out_data retains its last value after the handshake; it is meaningful only when out_valid=1.
- All XORs are bitwise and width-exact. The round counter is 5 bits and never wraps within a block.

Decomposition:
- Package present_pkg holds:
  - BLOCK_W, KEY_W, NUM_ROUNDS constants;
  - the 16-entry encrypt S-box constant array;
  - a pure function for pLayer;
  - a pure function for the key-schedule update;
  - the FSM state enum {IDLE, RUN, DONE}.
- One sub-module, sbox4_encrypt: a 4-bit combinational lookup from the package table.
  - 16 instances for the state.
  - 1 instance for the key nibble.

Test Plan:
- Reset then pt=0000000000000000, key=0 -> out_valid after 31 cycles, out_data=5579C1387B228445.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049.
- pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B. Hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0.
- pt=FFFFFFFFFFFFFFFF, key=all-F -> 3333DCD3213210D2. Drive out_ready=1 with a new in_valid in the same cycle -> back-to-back accept; the second result appears 31 cycles later.
- Assert rst at round 15 -> out_valid=0, out_data=0, in_ready=1 on the cycle after rst deasserts. The following block (pt=0, key=0) gives 5579C1387B228445.
- Toggle in_data/in_key during RUN -> result equals that of the originally accepted block.

Source files
------------

// File: rtl/present_pkg.sv
// Shared constants, S-box table, pLayer and key-schedule helpers, and FSM state
// type for the PRESENT-80 encrypt core.
package present_pkg;

  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 80;
  localparam int NUM_ROUNDS = 31;

  // Encrypt-direction S-box, element 0 first.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] din);
    logic [BLOCK_W-1:0] dout;
    dout = '0;
    for (int i = 0; i < BLOCK_W - 1; i++) begin
      dout[(16 * i) % (BLOCK_W - 1)] = din[i];
    end
    dout[BLOCK_W-1] = din[BLOCK_W-1];
    return dout;
  endfunction

  // top_sub is the S-box image of key[18:15], the nibble that the rotation
  // brings to the top of the register.
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] key,
                                                  input logic [4:0]       rc,
                                                  input logic [3:0]       top_sub);
    logic [KEY_W-1:0] rot;
    rot        = {key[18:0], key[KEY_W-1:19]};
    rot[79:76] = top_sub;
    rot[19:15] = rot[19:15] ^ rc;
    return rot;
  endfunction

endpackage

// File: rtl/present_encrypt_core_sbox4_encrypt.sv
// 4-bit combinational encrypt S-box lookup from the package table.
module sbox4_encrypt
  import present_pkg::*;
(
  input  logic [3:0] in_nib,
  output logic [3:0] out_nib
);

  assign out_nib = SBOX[in_nib];

endmodule

// File: rtl/present_encrypt_core.sv
// Iterative PRESENT-80 encryption: one SP round per clock, 31 rounds, final key
// whitening, valid/ready on both sides.
module present_encrypt_core
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data
);

  localparam logic [4:0] LAST_RC = 5'(NUM_ROUNDS);

  fsm_e               fsm_q, fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [4:0]         rc_q, rc_d;
  logic               out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;

  logic [BLOCK_W-1:0] sbox_in, sbox_out, round_state;
  logic [KEY_W-1:0]   next_key;
  logic [3:0]         key_top_sub;
  logic               accept;

  assign sbox_in = state_q ^ key_q[KEY_W-1:KEY_W-BLOCK_W];

  for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_sbox
    sbox4_encrypt u_sbox (
      .in_nib  (sbox_in[4*n +: 4]),
      .out_nib (sbox_out[4*n +: 4])
    );
  end

  sbox4_encrypt u_key_sbox (
    .in_nib  (key_q[18:15]),
    .out_nib (key_top_sub)
  );

  assign round_state = p_layer(sbox_out);
  assign next_key    = key_update(key_q, rc_q, key_top_sub);

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    end
  end

  assign accept = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    rc_d        = rc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = in_data;
          key_d   = in_key;
          rc_d    = 5'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_state;
        key_d   = next_key;
        rc_d    = rc_q + 5'd1;
        if (rc_q == LAST_RC) begin
          out_data_d  = round_state ^ next_key[KEY_W-1:KEY_W-BLOCK_W];
          out_valid_d = 1'b1;
          rc_d        = 5'd0;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
          if (accept) begin
            state_d = in_data;
            key_d   = in_key;
            rc_d    = 5'd1;
            fsm_d   = RUN;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      rc_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      rc_q        <= rc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_present_encrypt_core.sv
// Self-checking bench for present_encrypt_core: known-answer vectors, handshake
// corner cases and random blocks against a round-by-round PRESENT-80 model.
module tb_present_encrypt_core;

  localparam logic [63:0] SB_TAB = 64'h2174_8FE3_DA09_B65C;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int total = 0;
  int bad   = 0;

  present_encrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, t, p;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = SB_TAB[4*int'(s[4*n +: 4]) +: 4];
      for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : (b * 16) % 63] = t[b];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = SB_TAB[4*int'(k[79:76]) +: 4];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Called just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge.
  task automatic send(input logic [63:0] pt, input logic [79:0] k);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b out_data=%h want 0 0 0", in_ready, out_valid, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors;
    logic [63:0] pts [4] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [79:0] keys[4] = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
    logic [63:0] exps[4] = '{64'h5579_C138_7B22_8445, 64'hE72C_46C0_F594_5049,
                             64'hA112_FFC7_2F68_417B, 64'h3333_DCD3_2132_10D2};
    int cycles;
    for (int v = 0; v < 4; v++) begin
      send(pts[v], keys[v]);
      wait_out(cycles);
      total++;
      if (cycles !== 31) begin
        bad++;
        $display("FAIL kat%0d_latency: got %0d cycles want 31", v, cycles);
      end
      total++;
      if (out_data !== exps[v]) begin
        bad++;
        $display("FAIL kat%0d_data: got %h want %h", v, out_data, exps[v]);
      end
      if (v == 2) begin
        for (int h = 0; h < 10; h++) begin
          @(negedge clk);
          total++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exps[v]) begin
            bad++;
            $display("FAIL hold%0d: out_valid=%b in_ready=%b out_data=%h want 1 0 %h",
                     h, out_valid, in_ready, out_data, exps[v]);
          end
        end
      end
      if (v == 3) break;
      handshake();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL kat%0d_drain: out_valid=%b in_ready=%b want 0 1", v, out_valid, in_ready);
      end
    end
  endtask

  // Entered with the all-F/all-F result waiting in DONE.
  task automatic test_back_to_back;
    int cycles;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h0;
    in_key    = 80'h0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop: out_valid=%b want 0", out_valid);
    end
    wait_out(cycles);
    total++;
    if (cycles !== 31 || out_data !== 64'h5579_C138_7B22_8445) begin
      bad++;
      $display("FAIL b2b_second: cycles=%0d data=%h want 31 5579c1387b228445", cycles, out_data);
    end
    handshake();
  endtask

  task automatic test_reset_mid;
    int cycles;
    send({$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_hold: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_after: out_valid=%b out_data=%h in_ready=%b want 0 0 1", out_valid, out_data, in_ready);
    end
    send(64'h0, 80'h0);
    wait_out(cycles);
    total++;
    if (cycles !== 31 || out_data !== 64'h5579_C138_7B22_8445) begin
      bad++;
      $display("FAIL midrst_next: cycles=%0d data=%h want 31 5579c1387b228445", cycles, out_data);
    end
    handshake();
  endtask

  task automatic test_input_toggle;
    logic [63:0] pt, exp;
    logic [79:0] k;
    int cycles = 0;
    pt  = {$urandom, $urandom};
    k   = {16'($urandom), $urandom, $urandom};
    exp = present_ref(pt, k);
    send(pt, k);
    while (!out_valid && cycles < 100) begin
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      in_key   = {16'($urandom), $urandom, $urandom};
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    total++;
    if (cycles !== 31 || out_data !== exp) begin
      bad++;
      $display("FAIL toggle: cycles=%0d data=%h want 31 %h", cycles, out_data, exp);
    end
    handshake();
  endtask

  task automatic test_random;
    logic [63:0] pt, exp;
    logic [79:0] k;
    int cycles;
    for (int t = 0; t < 8; t++) begin
      pt  = {$urandom, $urandom};
      k   = {16'($urandom), $urandom, $urandom};
      exp = present_ref(pt, k);
      send(pt, k);
      wait_out(cycles);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if (cycles !== 31 || out_data !== exp) begin
        bad++;
        $display("FAIL rand%0d: cycles=%0d data=%h want 31 %h (pt=%h key=%h)", t, cycles, out_data, exp, pt, k);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_input_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
